// File: rtl/ip_pkg.sv
// Shared IP-layer definitions: TX mux FSM states, user sideband field layout
// and the round-robin pick helper used by the channel arbiter.
package ip_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_t;

    // User sideband layout {len, flag, type, offset, id}, LSB first
    localparam int USER_ID_LSB     = 0;
    localparam int USER_ID_W       = 16;
    localparam int USER_OFFSET_LSB = 16;
    localparam int USER_OFFSET_W   = 13;
    localparam int USER_TYPE_LSB   = 29;
    localparam int USER_TYPE_W     = 8;
    localparam int USER_FLAG_LSB   = 37;
    localparam int USER_FLAG_W     = 3;
    localparam int USER_LEN_LSB    = 40;
    localparam int USER_LEN_W      = 16;
    localparam int USER_TOTAL_W    = USER_LEN_LSB + USER_LEN_W;

    localparam int CHAN_MAX = 8;

    // First requester at or after ptr, modulo chan_num. ptr must be < chan_num.
    function automatic logic [2:0] rr_pick(
        input logic [CHAN_MAX-1:0] req,
        input logic [2:0]          ptr,
        input int unsigned         chan_num
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < CHAN_MAX; i++) begin
            if (i < chan_num) begin
                idx = 32'(ptr) + i;
                if (idx >= chan_num) begin
                    idx = idx - chan_num;
                end
                if (!found && req[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage registered valid/ready slice. Output holds until taken; a new
// beat may be loaded in the same cycle the current one drains.
module axis_reg_slice #(
    parameter int P_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [P_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [P_WIDTH-1:0] data_reg;
    logic               valid_reg;

    assign in_ready  = ~valid_reg | out_ready;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (in_valid && in_ready) begin
            data_reg  <= in_data;
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/ip_tx_chan_mux.sv
// N-channel frame-atomic round-robin multiplexer into the IP TX upper port.
// Optional per-channel frame counters when IP_TX_MUX_STATS_EN is defined.
module ip_tx_chan_mux
    import ip_pkg::*;
#(
    parameter int P_CHAN_NUM = 4,
    parameter int P_DATA_W   = 64,
    parameter int P_USER_W   = 56,
    parameter int P_KEEP_W   = P_DATA_W / 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [P_CHAN_NUM*P_DATA_W-1:0] s_axis_chan_data,
    input  logic [P_CHAN_NUM*P_USER_W-1:0] s_axis_chan_user,
    input  logic [P_CHAN_NUM*P_KEEP_W-1:0] s_axis_chan_keep,
    input  logic [P_CHAN_NUM-1:0]          s_axis_chan_last,
    input  logic [P_CHAN_NUM-1:0]          s_axis_chan_valid,
    output logic [P_CHAN_NUM-1:0]          s_axis_chan_ready,
    output logic [P_DATA_W-1:0]            m_axis_ip_data,
    output logic [P_USER_W-1:0]            m_axis_ip_user,
    output logic [P_KEEP_W-1:0]            m_axis_ip_keep,
    output logic                           m_axis_ip_last,
    output logic                           m_axis_ip_valid,
    input  logic                           m_axis_ip_ready,
    output logic [2:0]                     o_grant_chan
`ifdef IP_TX_MUX_STATS_EN
    ,
    output logic [P_CHAN_NUM*16-1:0]       o_frame_cnt
`endif
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_LOCK = LOCK;
    localparam int         PAY_W  = P_DATA_W + P_USER_W + P_KEEP_W + 1;

    logic [0:0]          state_reg;
    logic [2:0]          grant_reg;
    logic [2:0]          ptr_reg;

    logic [P_DATA_W-1:0] sel_data;
    logic [P_USER_W-1:0] sel_user;
    logic [P_KEEP_W-1:0] sel_keep;
    logic                sel_last;
    logic                sel_valid;

    logic                lock;
    logic                slice_in_valid;
    logic                slice_in_ready;
    logic                accept;
    logic                accept_last;
    logic [CHAN_MAX-1:0] req_ext;
    logic [2:0]          pick;
    logic [PAY_W-1:0]    slice_in_data;
    logic [PAY_W-1:0]    slice_out_data;

    // Only the granted channel's beat is ever presented to the output slice
    always_comb begin
        sel_data  = '0;
        sel_user  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int c = 0; c < P_CHAN_NUM; c++) begin
            if (grant_reg == 3'(c)) begin
                sel_data  = s_axis_chan_data[c*P_DATA_W +: P_DATA_W];
                sel_user  = s_axis_chan_user[c*P_USER_W +: P_USER_W];
                sel_keep  = s_axis_chan_keep[c*P_KEEP_W +: P_KEEP_W];
                sel_last  = s_axis_chan_last[c];
                sel_valid = s_axis_chan_valid[c];
            end
        end
    end

    assign lock           = (state_reg == S_LOCK);
    assign slice_in_valid = lock & sel_valid;
    assign accept         = slice_in_valid & slice_in_ready;
    assign accept_last    = accept & sel_last;
    assign req_ext        = CHAN_MAX'(s_axis_chan_valid);
    assign pick           = rr_pick(req_ext, ptr_reg, P_CHAN_NUM);
    assign slice_in_data  = {sel_last, sel_keep, sel_user, sel_data};

    genvar gi;
    generate
        for (gi = 0; gi < P_CHAN_NUM; gi++) begin : g_ready
            assign s_axis_chan_ready[gi] = lock & (grant_reg == 3'(gi)) & slice_in_ready;
        end
    endgenerate

    // Grant and pointer move only on the IDLE->LOCK edge; IDLE itself gives
    // the one ready-free cycle between frames.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (|s_axis_chan_valid) begin
                        state_reg <= S_LOCK;
                        grant_reg <= pick;
                        ptr_reg   <= (pick == 3'(P_CHAN_NUM - 1)) ? 3'd0 : pick + 3'd1;
                    end
                end
                S_LOCK: begin
                    if (accept_last) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    axis_reg_slice #(
        .P_WIDTH (PAY_W)
    ) u_out_slice (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .in_data   (slice_in_data),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .out_data  (slice_out_data),
        .out_valid (m_axis_ip_valid),
        .out_ready (m_axis_ip_ready)
    );

    assign m_axis_ip_data = slice_out_data[0 +: P_DATA_W];
    assign m_axis_ip_user = slice_out_data[P_DATA_W +: P_USER_W];
    assign m_axis_ip_keep = slice_out_data[P_DATA_W + P_USER_W +: P_KEEP_W];
    assign m_axis_ip_last = slice_out_data[PAY_W-1];
    assign o_grant_chan   = grant_reg;

`ifdef IP_TX_MUX_STATS_EN
    logic [15:0] frame_cnt_reg [P_CHAN_NUM];

    generate
        for (gi = 0; gi < P_CHAN_NUM; gi++) begin : g_stats
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    frame_cnt_reg[gi] <= '0;
                end else if (accept_last && (grant_reg == 3'(gi))) begin
                    frame_cnt_reg[gi] <= frame_cnt_reg[gi] + 16'd1;
                end
            end
            assign o_frame_cnt[gi*16 +: 16] = frame_cnt_reg[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ip_tx_chan_mux.sv
// Directed table-driven bench for ip_tx_chan_mux (4 channels, 64-bit data).
module tb_ip_tx_chan_mux;

    localparam int CN = 4;
    localparam int DW = 64;
    localparam int UW = 56;
    localparam int KW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CN*DW-1:0]  s_data = '0;
    logic [CN*UW-1:0]  s_user = '0;
    logic [CN*KW-1:0]  s_keep = '0;
    logic [CN-1:0]     s_last = '0;
    logic [CN-1:0]     s_valid = '0;
    logic [CN-1:0]     s_ready;
    logic [DW-1:0]     m_data;
    logic [UW-1:0]     m_user;
    logic [KW-1:0]     m_keep;
    logic              m_last;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [2:0]        grant;
`ifdef IP_TX_MUX_STATS_EN
    logic [CN*16-1:0]  frame_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cur_step = 0;

    always #5 clk = ~clk;

    ip_tx_chan_mux #(
        .P_CHAN_NUM (CN),
        .P_DATA_W   (DW),
        .P_USER_W   (UW)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .s_axis_chan_data  (s_data),
        .s_axis_chan_user  (s_user),
        .s_axis_chan_keep  (s_keep),
        .s_axis_chan_last  (s_last),
        .s_axis_chan_valid (s_valid),
        .s_axis_chan_ready (s_ready),
        .m_axis_ip_data    (m_data),
        .m_axis_ip_user    (m_user),
        .m_axis_ip_keep    (m_keep),
        .m_axis_ip_last    (m_last),
        .m_axis_ip_valid   (m_valid),
        .m_axis_ip_ready   (m_ready),
        .o_grant_chan      (grant)
`ifdef IP_TX_MUX_STATS_EN
        ,
        .o_frame_cnt       (frame_cnt)
`endif
    );

    // One row per cycle: inputs, then the outputs expected before the next edge.
    // tag = {channel, step at which the beat was accepted}
    typedef struct packed {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        mrdy;
        logic [3:0]  exp_rdy;
        logic        exp_mv;
        logic        exp_ml;
        logic [15:0] exp_tag;
        logic [2:0]  exp_gnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                                input logic mrdy, input logic [3:0] rdy, input logic mv,
                                input logic ml, input logic [15:0] tag, input logic [2:0] gnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.mrdy = mrdy; v.exp_rdy = rdy;
        v.exp_mv = mv; v.exp_ml = ml; v.exp_tag = tag; v.exp_gnt = gnt;
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [15:0] tag);
        return {tag[15:8], 48'h0, tag[7:0]};
    endfunction

    function automatic logic [UW-1:0] exp_user(input logic [15:0] tag);
        return {8'hA0 + tag[15:8], 40'h0, tag[7:0]};
    endfunction

    function automatic logic [KW-1:0] exp_keep(input logic [15:0] tag);
        return 8'hFF >> tag[15:8];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, cur_step, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [3:0] last, input logic mrdy,
                         input logic [7:0] step);
        for (int c = 0; c < CN; c++) begin
            s_data[c*DW +: DW] = {8'(c), 48'h0, step};
            s_user[c*UW +: UW] = {8'hA0 + 8'(c), 40'h0, step};
            s_keep[c*KW +: KW] = 8'hFF >> c;
        end
        s_valid = valid;
        s_last  = last;
        m_ready = mrdy;
    endtask

    initial begin
        // Test 1: ch0 4-beat frame, full throughput
        tbl.push_back(mk(1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 16'h0001, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 16'h0002, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 16'h0003, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 16'h0004, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 0));
        // Test 2: all channels with 2-beat frames from pointer 0
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 4'b0001, 1, 0, 16'h0008, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0000, 1, 1, 16'h0009, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0010, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0010, 1, 4'b0010, 1, 0, 16'h010B, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0000, 1, 1, 16'h010C, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 0, 0, 16'h0000, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 1, 4'b0100, 1, 0, 16'h020E, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0000, 1, 1, 16'h020F, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 0, 0, 16'h0000, 3));
        tbl.push_back(mk(0, 4'b1111, 4'b1000, 1, 4'b1000, 1, 0, 16'h0311, 3));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0000, 1, 1, 16'h0312, 3));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 4'b0001, 1, 0, 16'h0014, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 16'h0015, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 0));
        // Test 3: ch1 3-beat frame with downstream ready 1,0,0,1
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0010, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 1, 0, 16'h0119, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 1, 0, 16'h0119, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 16'h0119, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 0, 16'h011C, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 16'h011D, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 1));
        // Test 4: ch2 stalls 5 cycles mid-frame while ch1 waits
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 0, 0, 16'h0000, 2));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0100, 1, 0, 16'h0221, 2));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0100, 0, 0, 16'h0000, 2));
        tbl.push_back(mk(0, 4'b0110, 4'b0100, 1, 4'b0100, 0, 0, 16'h0000, 2));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0000, 1, 1, 16'h0227, 2));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 4'b0010, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 16'h0129, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 1));

        // Reset state
        drive(4'b0000, 4'b0000, 1'b1, 8'd0);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data",  m_data, 64'd0);
        chk("rst_m_user",  64'(m_user), 64'd0);
        chk("rst_m_keep",  64'(m_keep), 64'd0);
        chk("rst_m_last",  64'(m_last), 64'd0);
        chk("rst_ready",   64'(s_ready), 64'd0);
        chk("rst_grant",   64'(grant), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            cur_step = i;
            if (tbl[i].rst) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            drive(tbl[i].valid, tbl[i].last, tbl[i].mrdy, 8'(i));
            @(negedge clk);
            chk("ready",   64'(s_ready), 64'(tbl[i].exp_rdy));
            chk("m_valid", 64'(m_valid), 64'(tbl[i].exp_mv));
            chk("grant",   64'(grant),   64'(tbl[i].exp_gnt));
            if (tbl[i].exp_mv) begin
                chk("m_data", m_data,        exp_data(tbl[i].exp_tag));
                chk("m_user", 64'(m_user),   64'(exp_user(tbl[i].exp_tag)));
                chk("m_keep", 64'(m_keep),   64'(exp_keep(tbl[i].exp_tag)));
                chk("m_last", 64'(m_last),   64'(tbl[i].exp_ml));
            end
            @(posedge clk);
            #1;
        end

        // Test 5: asynchronous reset mid-frame, pointer restarts at 0
        cur_step = 100;
        drive(4'b0010, 4'b0000, 1'b1, 8'd100);
        @(posedge clk); #1;
        drive(4'b0010, 4'b0000, 1'b1, 8'd101);
        @(posedge clk); #1;
        chk("pre_rst_m_valid", 64'(m_valid), 64'd1);
        chk("pre_rst_grant",   64'(grant), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", 64'(m_valid), 64'd0);
        chk("async_rst_m_data",  m_data, 64'd0);
        chk("async_rst_grant",   64'(grant), 64'd0);
        chk("async_rst_ready",   64'(s_ready), 64'd0);
        #1 rst_n = 1'b1;
        cur_step = 102;
        drive(4'b0110, 4'b0110, 1'b1, 8'd102);
        @(posedge clk); #1;
        chk("post_rst_grant", 64'(grant), 64'd1);
        chk("post_rst_ready", 64'(s_ready), 64'b0010);
        @(posedge clk); #1;
        drive(4'b0000, 4'b0000, 1'b1, 8'd103);
        chk("post_rst_m_valid", 64'(m_valid), 64'd1);
        chk("post_rst_m_data",  m_data, exp_data(16'h0166));
        chk("post_rst_m_last",  64'(m_last), 64'd1);
        @(posedge clk); #1;

`ifdef IP_TX_MUX_STATS_EN
        // Test 6: three single-beat frames on ch1
        cur_step = 200;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(4'b0010, 4'b0010, 1'b1, 8'd200);
        repeat (6) @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000, 1'b1, 8'd201);
        @(posedge clk); #1;
        chk("frame_cnt_ch1", 64'(frame_cnt[31:16]), 64'd3);
        chk("frame_cnt_ch0", 64'(frame_cnt[15:0]),  64'd0);
        chk("frame_cnt_ch2", 64'(frame_cnt[47:32]), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
